cfg_regfile: RTL and testbench

//   Register bank directly downstream of the AXI-Lite config slave: consumes its
//   m_addr/m_wdata/m_wstrb memory interface and returns m_rdata. Holds ID, control,

---
 rtl/cfg_regfile.sv | 176 +++++++++++++++++
 tb/tb_cfg_regfile.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_regfile
//  Purpose  : Configuration register bank behind the AXI-Lite config slave.
//             It holds the ID, CTRL, STATUS (W1C), LOAD, COUNT and SCRATCH
//             registers. A down-counter timer raises a level interrupt when
//             it expires.
//  Ports    : s_axi_aclk    - clock
//             s_axi_aresetn - async active-low reset (internally synchronised
//                             on deassertion)
//             m_addr        - byte address (write addr when m_wstrb=1)
//             m_wdata       - write data, valid while m_wstrb=1
//             m_wstrb       - single-cycle write enable
//             m_rdata       - combinational read data for m_addr
//             irq           - registered level interrupt
//             ctrl_o        - CTRL[2:0] to fabric
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_regfile #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h07C0_0001
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_wstrb,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  irq,
  output logic [2:0]            ctrl_o
);

  localparam logic [5:0] WORD_ID      = 6'h00;
  localparam logic [5:0] WORD_CTRL    = 6'h01;
  localparam logic [5:0] WORD_STATUS  = 6'h02;
  localparam logic [5:0] WORD_LOAD    = 6'h03;
  localparam logic [5:0] WORD_COUNT   = 6'h04;
  localparam logic [5:0] WORD_SCRATCH = 6'h05;

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Reset synchroniser: assertion is immediate, release is aligned to the
  // clock so no register sees a deassertion close to an edge.
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // State
  logic [2:0]            ctrl_reg;     // [0] tmr_en, [1] irq_en, [2] auto_reload
  logic [1:0]            status_reg;   // [0] expired, [1] overrun
  logic [DATA_WIDTH-1:0] load_reg;
  logic [DATA_WIDTH-1:0] count_reg;
  logic [DATA_WIDTH-1:0] scratch_reg;
  logic                  irq_reg;

  // Address decode
  logic       addr_ok;
  logic [5:0] word;

  assign addr_ok = (m_addr[ADDR_WIDTH-1:8] == '0) && (m_addr[1:0] == 2'b00);
  assign word    = m_addr[7:2];

  logic wr_ctrl;
  logic wr_status;
  logic wr_load;
  logic wr_scratch;
  logic soft_rst;

  assign wr_ctrl    = m_wstrb && addr_ok && (word == WORD_CTRL);
  assign wr_status  = m_wstrb && addr_ok && (word == WORD_STATUS);
  assign wr_load    = m_wstrb && addr_ok && (word == WORD_LOAD);
  assign wr_scratch = m_wstrb && addr_ok && (word == WORD_SCRATCH);
  assign soft_rst   = wr_ctrl && m_wdata[31];

  // Timer expiry: enabled while already at zero.
  logic expire;
  assign expire = ctrl_reg[0] && (count_reg == '0);

  logic [2:0]            ctrl_nxt;
  logic [1:0]            status_nxt;
  logic [DATA_WIDTH-1:0] count_nxt;

  always_comb begin
    ctrl_nxt   = ctrl_reg;
    status_nxt = status_reg;
    count_nxt  = count_reg;

    // Timer
    if (ctrl_reg[0]) begin
      if (count_reg != '0) begin
        count_nxt = count_reg - ONE;
      end else begin
        count_nxt   = ctrl_reg[2] ? load_reg : '0;
        ctrl_nxt[0] = ctrl_reg[2];
      end
    end

    // W1C is applied first so that a simultaneous expiry set wins.
    if (wr_status) begin
      status_nxt = status_reg & ~m_wdata[1:0];
    end
    if (expire) begin
      status_nxt[0] = 1'b1;
      if (status_reg[0]) begin
        status_nxt[1] = 1'b1;
      end
    end

    // Software writes override the timer's own updates.
    if (wr_ctrl) begin
      ctrl_nxt = soft_rst ? 3'b000 : m_wdata[2:0];
    end
    if (soft_rst) begin
      status_nxt = 2'b00;
      count_nxt  = '0;
    end
    if (wr_load) begin
      count_nxt = m_wdata;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg    <= 3'b000;
      status_reg  <= 2'b00;
      load_reg    <= '0;
      count_reg   <= '0;
      scratch_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      ctrl_reg   <= ctrl_nxt;
      status_reg <= status_nxt;
      count_reg  <= count_nxt;
      // Follows the current register values, so irq lags expired by a cycle
      // and drops one cycle after a clear or soft reset.
      irq_reg    <= ctrl_reg[1] && status_reg[0];
      if (wr_load) begin
        load_reg <= m_wdata;
      end
      if (wr_scratch) begin
        scratch_reg <= m_wdata;
      end
    end
  end

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    m_rdata = '0;
    if (addr_ok) begin
      case (word)
        WORD_ID:      m_rdata = ID_VALUE[DATA_WIDTH-1:0];
        WORD_CTRL:    m_rdata = {{(DATA_WIDTH-3){1'b0}}, ctrl_reg};
        WORD_STATUS:  m_rdata = {{(DATA_WIDTH-2){1'b0}}, status_reg};
        WORD_LOAD:    m_rdata = load_reg;
        WORD_COUNT:   m_rdata = count_reg;
        WORD_SCRATCH: m_rdata = scratch_reg;
        default:      m_rdata = '0;
      endcase
    end
  end

  assign irq    = irq_reg;
  assign ctrl_o = ctrl_reg;

endmodule
`default_nettype wire

// File: tb/tb_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_regfile
//  Purpose  : Self-checking bench for cfg_regfile. Directed scenarios are
//             followed by a randomised phase, all compared against a
//             behavioural register-map model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_regfile;

  logic        clk;
  logic        aresetn;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wstrb;
  logic [31:0] m_rdata;
  logic        irq;
  logic [2:0]  ctrl_o;

  int tests = 0;
  int fails = 0;

  cfg_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_VALUE   (32'h07C0_0001)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_rdata       (m_rdata),
    .irq           (irq),
    .ctrl_o        (ctrl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the register map
  logic [2:0]  md_ctrl;
  logic [1:0]  md_status;
  logic [31:0] md_load;
  logic [31:0] md_count;
  logic [31:0] md_scratch;
  logic        md_irq;

  task automatic model_reset();
    md_ctrl    = 3'd0;
    md_status  = 2'd0;
    md_load    = 32'd0;
    md_count   = 32'd0;
    md_scratch = 32'd0;
    md_irq     = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a[31:8] == 24'd0 && a[1:0] == 2'd0) begin
      case (a[7:0])
        8'h00: v = 32'h07C0_0001;
        8'h04: v = {29'd0, md_ctrl};
        8'h08: v = {30'd0, md_status};
        8'h0C: v = md_load;
        8'h10: v = md_count;
        8'h14: v = md_scratch;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  // One clock edge of the register map: the timer acts first, then any
  // software write is layered on top.
  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [2:0]  c;
    logic [1:0]  s;
    logic [31:0] n;
    logic        was_expired;
    c = md_ctrl;
    s = md_status;
    n = md_count;
    was_expired = md_status[0];
    md_irq = md_ctrl[1] & md_status[0];
    if (we && a[31:8] == 24'd0 && a[1:0] == 2'd0 && a[7:0] == 8'h08)
      s = s & ~d[1:0];
    if (md_ctrl[0]) begin
      if (md_count > 0) begin
        n = md_count - 1;
      end else begin
        s[0] = 1'b1;
        if (was_expired) s[1] = 1'b1;
        n    = md_ctrl[2] ? md_load : 32'd0;
        c[0] = md_ctrl[2];
      end
    end
    if (we && a[31:8] == 24'd0 && a[1:0] == 2'd0) begin
      case (a[7:0])
        8'h04: begin
          if (d[31]) begin
            c = 3'd0;
            s = 2'd0;
            n = 32'd0;
          end else begin
            c = d[2:0];
          end
        end
        8'h0C: begin
          md_load = d;
          n       = d;
        end
        8'h14: md_scratch = d;
        default: ;
      endcase
    end
    md_ctrl   = c;
    md_status = s;
    md_count  = n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle, started just after a falling edge: check the read mux for
  // the driven address, clock it, then check the registered outputs.
  task automatic bus_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
    m_wstrb = we;
    m_addr  = a;
    m_wdata = d;
    #1;
    check("rdata", m_rdata, model_read(a));
    @(posedge clk);
    model_edge(we, a, d);
    @(negedge clk);
    check("irq", {31'd0, irq}, {31'd0, md_irq});
    check("ctrl_o", {29'd0, ctrl_o}, {29'd0, md_ctrl});
    m_wstrb = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(1'b1, a, d);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_wstrb = 1'b0;
    m_addr  = a;
    #1;
    check(tag, m_rdata, exp);
    bus_cycle(1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 32'h10, 32'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] rdv;
  logic        rwe;

  initial begin
    aresetn = 1'b0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    m_wstrb = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    idle(4);

    // Reset values
    rd_expect("rst_id", 32'h00, 32'h07C0_0001);
    rd_expect("rst_ctrl", 32'h04, 32'd0);
    rd_expect("rst_status", 32'h08, 32'd0);
    rd_expect("rst_count", 32'h10, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Scratch and unmapped accesses
    wr(32'h14, 32'hDEAD_BEEF);
    rd_expect("scratch", 32'h14, 32'hDEAD_BEEF);
    wr(32'h40, 32'h1234_5678);
    rd_expect("unmapped_rd", 32'h40, 32'd0);
    rd_expect("scratch_kept", 32'h14, 32'hDEAD_BEEF);
    wr(32'h114, 32'h0BAD_0BAD);
    wr(32'h16, 32'h0BAD_0BAD);
    rd_expect("scratch_hi_mis", 32'h14, 32'hDEAD_BEEF);

    // One-shot timer with interrupt: expiry on the 6th enabled edge
    wr(32'h0C, 32'd5);
    wr(32'h04, 32'd3);
    for (int i = 0; i < 6; i++) rd_expect("os_wait", 32'h08, 32'd0);
    rd_expect("os_expired", 32'h08, 32'd1);
    check("os_irq_hi", {31'd0, irq}, 32'd1);
    rd_expect("os_count", 32'h10, 32'd0);
    rd_expect("os_ctrl", 32'h04, 32'd2);
    wr(32'h08, 32'd1);
    idle(1);
    check("os_irq_lo", {31'd0, irq}, 32'd0);
    rd_expect("os_cleared", 32'h08, 32'd0);

    // Auto-reload: period LOAD+1, overrun after the second expiry
    wr(32'h0C, 32'd2);
    wr(32'h04, 32'd5);
    rd_expect("ar_c0", 32'h10, 32'd2);
    rd_expect("ar_c1", 32'h10, 32'd1);
    rd_expect("ar_c2", 32'h10, 32'd0);
    rd_expect("ar_c3", 32'h10, 32'd2);
    rd_expect("ar_c4", 32'h10, 32'd1);
    rd_expect("ar_c5", 32'h10, 32'd0);
    rd_expect("ar_status", 32'h08, 32'd3);

    // W1C coincident with expiry: set wins
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'd1);
    wr(32'h04, 32'd5);
    idle(1);
    wr(32'h08, 32'd1);
    rd_expect("w1c_vs_set", 32'h08, 32'd1);

    // LOAD=0 with auto-reload: expiry every cycle, overrun on the second
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'd0);
    wr(32'h04, 32'd5);
    rd_expect("l0_first", 32'h08, 32'd0);
    rd_expect("l0_exp", 32'h08, 32'd1);
    rd_expect("l0_ovr", 32'h08, 32'd3);

    // Soft reset keeps LOAD and SCRATCH
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'd100);
    wr(32'h14, 32'd7);
    wr(32'h04, 32'd3);
    idle(3);
    wr(32'h04, 32'h8000_0007);
    rd_expect("sr_ctrl", 32'h04, 32'd0);
    rd_expect("sr_count", 32'h10, 32'd0);
    rd_expect("sr_status", 32'h08, 32'd0);
    rd_expect("sr_load", 32'h0C, 32'd100);
    rd_expect("sr_scratch", 32'h14, 32'd7);

    // Asynchronous reset mid-count
    wr(32'h0C, 32'd50);
    wr(32'h04, 32'd3);
    idle(3);
    m_addr = 32'h10;
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check("ar_rst_count", m_rdata, 32'd0);
    check("ar_rst_irq", {31'd0, irq}, 32'd0);
    check("ar_rst_ctrl_o", {29'd0, ctrl_o}, 32'd0);
    m_addr = 32'h0C;
    #1;
    check("ar_rst_load", m_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    idle(4);
    rd_expect("post_rst_scratch", 32'h14, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: ra = 32'h00;
        1: ra = 32'h04;
        2: ra = 32'h08;
        3: ra = 32'h0C;
        4: ra = 32'h10;
        5: ra = 32'h14;
        6: ra = 32'h40;
        7: ra = 32'h15;
        8: ra = 32'h104;
        default: ra = 32'h04;
      endcase
      rwe = ($urandom_range(0, 9) < 4);
      case (ra)
        32'h04:  rdv = ($urandom & 32'h7) | (($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'd0);
        32'h08:  rdv = $urandom & 32'h3;
        32'h0C:  rdv = $urandom_range(0, 6);
        default: rdv = $urandom;
      endcase
      bus_cycle(rwe, ra, rdv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
